// File: rtl/adc_moving_sum_win.sv
// Moving-window sum and average over the last 2^DEPTH_LOG2 ADC samples, one registered output stage.
// Build option: define ADC_MOVING_SUM_OFFSET_BIN_EN for offset-binary input (unsigned sum); default is two's complement.
module adc_moving_sum_win #(
    parameter int DATA_W     = 24,
    parameter int DEPTH_LOG2 = 4,
    parameter int OUT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic [DATA_W-1:0]     i_adc_data,
    input  logic                  i_adc_valid,
    output logic [OUT_W-1:0]      o_sum,
    output logic [DATA_W-1:0]     o_avg,
    output logic                  o_valid,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_fill_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [OUT_W-1:0]      acc_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam ptr_t PTR_ONE   = ptr_t'(1);

    function automatic data_t conv_sample(input data_t d);
`ifdef ADC_MOVING_SUM_OFFSET_BIN_EN
        conv_sample = {~d[DATA_W-1], d[DATA_W-2:0]};
`else
        conv_sample = d;
`endif
    endfunction

    function automatic acc_t widen(input data_t v);
`ifdef ADC_MOVING_SUM_OFFSET_BIN_EN
        widen = {{(OUT_W-DATA_W){1'b0}}, v};
`else
        widen = {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
`endif
    endfunction

    data_t  mem_q [DEPTH];
    data_t  mem_d [DEPTH];
    ptr_t   wr_ptr_q, wr_ptr_d;
    acc_t   acc_q, acc_d;
    cnt_t   fill_cnt_q, fill_cnt_d;
    state_t state_q, state_d;
    logic   pend_q, pend_d;

    acc_t   sum_q, sum_d;
    data_t  avg_q, avg_d;
    logic   valid_q, valid_d;
    logic   full_q, full_d;
    cnt_t   fill_out_q, fill_out_d;

    data_t  sample_s;
    data_t  old_s;
    data_t  avg_s;

    // Window datapath: the buffer starts at zero, so subtracting the evicted entry is always exact.
    always_comb begin
        sample_s   = conv_sample(i_adc_data);
        old_s      = mem_q[wr_ptr_q];
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        acc_d      = acc_q;
        fill_cnt_d = fill_cnt_q;
        pend_d     = 1'b0;
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d   = '0;
            acc_d      = '0;
            fill_cnt_d = '0;
        end else if (i_adc_valid) begin
            mem_d[wr_ptr_q] = sample_s;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            acc_d           = acc_q + widen(sample_s) - widen(old_s);
            pend_d          = 1'b1;
            if (fill_cnt_q != DEPTH_CNT) begin
                fill_cnt_d = fill_cnt_q + CNT_ONE;
            end else begin
                fill_cnt_d = fill_cnt_q;
            end
        end else begin
            pend_d = 1'b0;
        end
    end

    // Fill state machine: EMPTY -> FILLING -> FULL, back to EMPTY only on clear.
    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = ST_EMPTY;
        end else if (i_adc_valid) begin
            case (state_q)
                ST_EMPTY, ST_FILLING: state_d = (fill_cnt_d == DEPTH_CNT) ? ST_FULL : ST_FILLING;
                ST_FULL:              state_d = ST_FULL;
                default:              state_d = ST_EMPTY;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Average always divides by the full window length, even while filling.
    always_comb begin
`ifdef ADC_MOVING_SUM_OFFSET_BIN_EN
        avg_s = acc_q[DEPTH_LOG2 +: DATA_W];
`else
        avg_s = data_t'($signed(acc_q) >>> DEPTH_LOG2);
`endif
    end

    // Output stage: publish the accumulator one edge after the sample was taken.
    always_comb begin
        sum_d      = sum_q;
        avg_d      = avg_q;
        valid_d    = 1'b0;
        full_d     = full_q;
        fill_out_d = fill_out_q;
        if (i_clr) begin
            sum_d      = '0;
            avg_d      = '0;
            full_d     = 1'b0;
            fill_out_d = '0;
        end else if (pend_q) begin
            sum_d      = acc_q;
            avg_d      = avg_s;
            valid_d    = 1'b1;
            full_d     = (state_q == ST_FULL);
            fill_out_d = fill_cnt_q;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            acc_q      <= '0;
            fill_cnt_q <= '0;
            state_q    <= ST_EMPTY;
            pend_q     <= 1'b0;
            sum_q      <= '0;
            avg_q      <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            fill_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            acc_q      <= acc_d;
            fill_cnt_q <= fill_cnt_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            sum_q      <= sum_d;
            avg_q      <= avg_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            fill_out_q <= fill_out_d;
        end
    end

    assign o_sum      = sum_q;
    assign o_avg      = avg_q;
    assign o_valid    = valid_q;
    assign o_full     = full_q;
    assign o_fill_cnt = fill_out_q;

endmodule

// File: tb/tb_adc_moving_sum_win.sv
// Bench for adc_moving_sum_win: window-sum reference model feeding a scoreboard, plus directed corner sequences.
module tb_adc_moving_sum_win;
    localparam int DW    = 24;
    localparam int DL    = 4;
    localparam int OW    = 32;
    localparam int DEPTH = 16;
    localparam int NVEC  = 24;

`ifdef ADC_MOVING_SUM_OFFSET_BIN_EN
    localparam logic [DW-1:0] FILL_DATA = 24'h000000;
    localparam logic [OW-1:0] FILL_SUM  = 32'h08000000;
    localparam logic [DW-1:0] FILL_AVG  = 24'h800000;
    localparam logic [OW-1:0] FIVE_SUM  = 32'h00800005;
`else
    localparam logic [DW-1:0] FILL_DATA = 24'hFFFFFF;
    localparam logic [OW-1:0] FILL_SUM  = 32'hFFFFFFF0;
    localparam logic [DW-1:0] FILL_AVG  = 24'hFFFFFF;
    localparam logic [OW-1:0] FIVE_SUM  = 32'h00000005;
`endif

    typedef logic [DL:0] fill_t;
    typedef struct packed {
        logic [OW-1:0] sum;
        logic [DW-1:0] avg;
        fill_t         fill;
        logic          full;
    } exp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic          clr;
        logic          exp_out;
        exp_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          vld;
    logic [DW-1:0] din;
    logic [OW-1:0] o_sum;
    logic [DW-1:0] o_avg;
    logic          o_valid;
    logic          o_full;
    fill_t         o_fill_cnt;

    exp_t   sb_q[$];
    longint hist[$];
    int     total = 0;
    int     bad = 0;
    int     n_valid = 0;

    always #5 clk = ~clk;

    adc_moving_sum_win dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_clr       (clr),
        .i_adc_data  (din),
        .i_adc_valid (vld),
        .o_sum       (o_sum),
        .o_avg       (o_avg),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_fill_cnt  (o_fill_cnt)
    );

    function automatic longint conv(input logic [DW-1:0] d);
`ifdef ADC_MOVING_SUM_OFFSET_BIN_EN
        logic [DW-1:0] t;
        t = {~d[DW-1], d[DW-2:0]};
        return longint'(t);
`else
        return longint'($signed(d));
`endif
    endfunction

    // Reference: explicit sum over the retained history, not a running accumulator.
    function automatic exp_t model_step(input logic [DW-1:0] d);
        exp_t   e;
        longint s;
        longint sh;
        s = 0;
        hist.push_back(conv(d));
        if (hist.size() > DEPTH) void'(hist.pop_front());
        foreach (hist[i]) s += hist[i];
        sh     = s >>> DL;
        e.sum  = s[OW-1:0];
        e.avg  = sh[DW-1:0];
        e.fill = fill_t'(hist.size());
        e.full = (hist.size() == DEPTH);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_sum"}, 64'(o_sum), 64'd0);
        check({nm, "_avg"}, 64'(o_avg), 64'd0);
        check({nm, "_flags"}, 64'({o_valid, o_full, o_fill_cnt}), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [DW-1:0] d);
        din = d;
        vld = 1'b1;
        clr = 1'b0;
        sb_q.push_back(model_step(d));
        tick();
        vld = 1'b0;
    endtask

    task automatic do_clear();
        idle(1);
        clr = 1'b1;
        hist.delete();
        tick();
        clr = 1'b0;
        idle(1);
    endtask

    task automatic fill_test(input string nm);
        for (int k = 0; k < DEPTH; k++) send(FILL_DATA);
        idle(2);
        check({nm, "_sum"}, 64'(o_sum), 64'(FILL_SUM));
        check({nm, "_avg"}, 64'(o_avg), 64'(FILL_AVG));
        check({nm, "_full_cnt"}, 64'({o_full, o_fill_cnt}), 64'({1'b1, fill_t'(DEPTH)}));
    endtask

    // Scoreboard: every output strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid) begin
            n_valid++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_valid got sum=%h avg=%h", o_sum, o_avg);
            end else begin
                e = sb_q.pop_front();
                if ({o_sum, o_avg, o_fill_cnt, o_full} !== e) begin
                    bad++;
                    $display("FAIL sb_out got sum=%h avg=%h fill=%0d full=%b want sum=%h avg=%h fill=%0d full=%b",
                             o_sum, o_avg, o_fill_cnt, o_full, e.sum, e.avg, e.fill, e.full);
                end
            end
        end
    end

    initial begin
        vec_t tbl[NVEC];
        int   nv0;

        rst_n = 1'b0;
        clr   = 1'b0;
        vld   = 1'b0;
        din   = '0;
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        idle(3);
        check_zero("idle");

        for (int i = 0; i < NVEC; i++) begin
            tbl[i].data    = DW'($urandom);
            tbl[i].clr     = (i == 14);
            tbl[i].valid   = (i % 5 != 3);
            tbl[i].exp_out = 1'b0;
            tbl[i].exp     = '0;
            if (tbl[i].clr) begin
                hist.delete();
            end else if (tbl[i].valid) begin
                tbl[i].exp     = model_step(tbl[i].data);
                tbl[i].exp_out = 1'b1;
            end else begin
                tbl[i].exp_out = 1'b0;
            end
        end
        for (int i = 0; i < NVEC; i++) begin
            din = tbl[i].data;
            vld = tbl[i].valid;
            clr = tbl[i].clr;
            if (tbl[i].exp_out) sb_q.push_back(tbl[i].exp);
            tick();
        end
        idle(2);
        check("table_drain", 64'(sb_q.size()), 64'd0);

        do_clear();
        check_zero("clear");

        fill_test("fill");

`ifndef ADC_MOVING_SUM_OFFSET_BIN_EN
        do_clear();
        nv0 = n_valid;
        for (int k = 1; k <= 20; k++) begin
            send(DW'(k));
            if (k == 17) check("wrap_sum16", 64'(o_sum), 64'd136);
        end
        idle(2);
        check("wrap_sum20", 64'(o_sum), 64'd200);
        check("wrap_avg20", 64'(o_avg), 64'd12);
        check("wrap_nvalid", 64'(n_valid - nv0), 64'd20);
`endif

        idle(1);
        check("pre_collision_full", 64'(o_full), 64'd1);
        din = 24'h000007;
        vld = 1'b1;
        clr = 1'b1;
        hist.delete();
        tick();
        vld = 1'b0;
        clr = 1'b0;
        idle(1);
        check_zero("collision");
        send(24'h000005);
        idle(2);
        check("collision_next_sum", 64'(o_sum), 64'(FIVE_SUM));
        check("collision_next_cnt", 64'({o_full, o_fill_cnt}), 64'd1);

        do_clear();
        for (int k = 0; k < 7; k++) send(DW'($urandom));
        idle(1);
        check("pre_rst_cnt", 64'(o_fill_cnt), 64'd7);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        sb_q.delete();
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fill_test("refill");

        idle(3);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_moving_sum_win.md
# adc_moving_sum_win

Parametrised moving-window accumulator for the MPS ADC path. It sums the last 2^DEPTH_LOG2 ADC samples with a running add/subtract accumulator over a circular buffer, and reports both the sum and the window average. It sits between the ADC interface and the floating-point conversion stage. It also provides fill status, a synchronous clear, and an output-valid strobe.

## Interface
Parameters:
- DATA_W, 24, ADC sample width.
- DEPTH_LOG2, 4, log2 of the window length; DEPTH = 2^DEPTH_LOG2, legal range 1..8.
- OUT_W, 32, width of o_sum; must be at least DATA_W + DEPTH_LOG2.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst  in  1  asynchronous, active-low reset.
- i_clr  in  1  synchronous window clear, 1-cycle pulse or level.
- i_adc_data  in  DATA_W  ADC sample, two's complement.
- i_adc_valid  in  1  sample strobe; may be asserted every cycle.
- o_sum  out  OUT_W  sum of the last DEPTH converted samples.
- o_avg  out  DATA_W  o_sum >> DEPTH_LOG2, truncated.
- o_valid  out  1  1-cycle pulse when o_sum and o_avg update.
- o_full  out  1  high once DEPTH samples are in the window since the last reset or clear.
- o_fill_cnt  out  DEPTH_LOG2+1  number of samples in the window, saturating at DEPTH.

## Operation
- Converted sample x:
  - Offset-binary mode: x = {~d[MSB], d[MSB-1:0]}, treated as unsigned.
  - Signed mode: x = d, sign-extended.
  - See Configuration for which mode is built.
- Storage:
  - Circular buffer of DEPTH entries, DATA_W wide.
  - Write pointer wr_ptr is DEPTH_LOG2 bits and wraps naturally from DEPTH-1 to 0.
  - Accumulator acc is OUT_W bits.
- On a valid cycle (i_adc_valid=1, i_clr=0):
  - old = buf[wr_ptr]
  - buf[wr_ptr] <= x
  - wr_ptr <= wr_ptr+1
  - acc <= acc + x − old, evaluated at OUT_W width with sign/zero extension matching the mode.
- The subtraction is exact because buffer entries are zero before they are first written. No overflow is possible given the OUT_W rule.
- Fill FSM:
  - States EMPTY → FILLING → FULL.
  - EMPTY → FILLING on the first valid.
  - FILLING → FULL on the valid that makes fill_cnt = DEPTH.
  - FULL holds until clear or reset.
  - o_full = (state==FULL).
  - o_fill_cnt increments per valid and stops at DEPTH.
- During FILLING, o_sum covers only the samples received so far; missing slots count as zero. o_avg still divides by DEPTH.
- o_avg:
  - Offset mode: acc[DEPTH_LOG2 +: DATA_W].
  - Signed mode: arithmetic shift right by DEPTH_LOG2, truncated to DATA_W.
- Clear (i_clr=1):
  - Zeroes all buffer entries, acc, wr_ptr, fill_cnt, o_sum and o_avg.
  - FSM goes to EMPTY and o_valid is forced to 0.
  - Clear takes priority over a simultaneous i_adc_valid; that sample is discarded.
- Idle cycles (i_adc_valid=0): all state and outputs hold, and o_valid=0.

## Timing
- Reset (i_rst=0, asynchronous):
  - All outputs go to 0: o_sum, o_avg, o_valid, o_full, o_fill_cnt.
  - Buffer, acc, wr_ptr go to 0; FSM goes to EMPTY.
- Reset mid-window discards the whole window. The first valid after reset release restarts filling.
- Latency: sample accepted at edge N appears in o_sum/o_avg after edge N+1. o_valid is high for exactly the cycle after edge N+1. This single registered stage is used for timing closure.
- Back-to-back valids every cycle give one o_valid per sample at full throughput.
- o_full and o_fill_cnt update in the same cycle as the matching o_sum update.
- A clear at edge N makes all outputs 0 after edge N+1. A valid at edge N+1 is accepted normally.

## Configuration
- Macro: ADC_MOVING_SUM_OFFSET_BIN_EN.
- Defined:
  - Offset-binary mode; input MSB is inverted before storage.
  - acc, o_sum and o_avg are unsigned.
  - This matches the existing float-conversion stage input format.
- Undefined:
  - Signed mode; samples are stored unchanged.
  - acc and o_sum are two's complement of OUT_W bits; o_avg is signed.

## Test plan
- Reset/idle: i_rst low, then release with no valids. Required: all outputs 0, o_full=0, o_fill_cnt=0, no o_valid.
- Offset-mode fill (macro defined, defaults): 16 valids of 0x000000. Required:
  - o_fill_cnt steps 1..16; o_full rises with the 16th o_valid.
  - Final o_sum=0x08000000, o_avg=0x800000.
- Signed wrap (macro undefined): feed 1,2,…,20 back-to-back. Required:
  - After the 16th sample, o_sum=136.
  - After the 20th sample, o_sum=200 (5..20) and o_avg=12.
  - Exactly 20 o_valid pulses.
- Signed negative (macro undefined): 16 samples of 0xFFFFFF. Required: o_sum=0xFFFFFFF0, o_avg=0xFFFFFF.
- Clear collision: with the window FULL, assert i_clr and i_adc_valid together. Required:
  - All outputs 0 one cycle later, o_valid stays 0, o_full=0.
  - The next valid of 5 (signed build) gives o_sum=5, o_fill_cnt=1.
- Async reset mid-window: pulse i_rst low between clock edges after 7 samples. Required:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - Refilling then reproduces the fill-test results.
